// File: rtl/sqrt_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative square-rooter among NREQ requesters.
// Handshake: req is a level held until the one-cycle ack; results return as a one-cycle res_valid pulse.
module sqrt_share_arbiter #(
    parameter int NREQ    = 3,
    parameter int NBITS   = 21,
    parameter int MBITS   = (NBITS + 1) / 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_flag,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NBITS-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       res_valid,
    output logic [MBITS-1:0]      res_answer,
    output logic                  res_err,
    output logic                  busy,
    output logic                  sq_start,
    output logic [NBITS-1:0]      sq_data,
    input  logic [MBITS-1:0]      sq_answer,
    input  logic                  sq_done,
    output logic [2:0]            dbg_state
);

    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_ARM     = 3'd2,
        S_WAIT    = 3'd3,
        S_RESPOND = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic              frame_pend_q, frame_pend_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   res_valid_q, res_valid_d;
    logic [MBITS-1:0]  res_answer_q, res_answer_d;
    logic              res_err_q, res_err_d;
    logic              busy_q, busy_d;
    logic              sq_start_q, sq_start_d;
    logic [NBITS-1:0]  sq_data_q, sq_data_d;

    logic              found;
    logic [PW-1:0]     pick;

    // First set request at or above the pointer, wrapping; a frame pulse restarts the search at 0.
    always_comb begin
        logic [PW:0] base;
        logic [PW:0] idx;
        found = 1'b0;
        pick  = '0;
        base  = frame_flag ? '0 : {1'b0, ptr_q};
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = base + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        wd_d         = wd_q;
        frame_pend_d = frame_pend_q | frame_flag;
        ack_d        = '0;
        res_valid_d  = '0;
        res_answer_d = res_answer_q;
        res_err_d    = res_err_q;
        sq_start_d   = 1'b0;
        sq_data_d    = sq_data_q;
        case (state_q)
            S_IDLE: begin
                res_err_d    = 1'b0;
                frame_pend_d = 1'b0;
                if (frame_flag) ptr_d = '0;
                if (found) begin
                    gnt_d      = pick;
                    sq_data_d  = req_data[pick*NBITS +: NBITS];
                    sq_start_d = 1'b1;
                    ack_d      = NREQ'(1) << pick;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_ARM;
            // sq_done is still high from the idle rooter here, so it is not looked at.
            S_ARM: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sq_done) begin
                    res_answer_d = sq_answer;
                    res_err_d    = 1'b0;
                    state_d      = S_RESPOND;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WW'(TIMEOUT - 1)) begin
                        res_answer_d = '0;
                        res_err_d    = 1'b1;
                        state_d      = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                res_valid_d = NREQ'(1) << gnt_q;
                if (frame_pend_q || frame_flag) ptr_d = '0;
                else ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            wd_q         <= '0;
            frame_pend_q <= 1'b0;
            ack_q        <= '0;
            res_valid_q  <= '0;
            res_answer_q <= '0;
            res_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            sq_start_q   <= 1'b0;
            sq_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            wd_q         <= wd_d;
            frame_pend_q <= frame_pend_d;
            ack_q        <= ack_d;
            res_valid_q  <= res_valid_d;
            res_answer_q <= res_answer_d;
            res_err_q    <= res_err_d;
            busy_q       <= busy_d;
            sq_start_q   <= sq_start_d;
            sq_data_q    <= sq_data_d;
        end
    end

    assign ack        = ack_q;
    assign res_valid  = res_valid_q;
    assign res_answer = res_answer_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;
    assign sq_start   = sq_start_q;
    assign sq_data    = sq_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Bench for sqrt_share_arbiter: behavioural rooter, round-robin reference model and
// a scoreboard monitor that checks every ack and every res_valid pulse.
module tb_sqrt_share_arbiter;
  localparam int NREQ = 3;
  localparam int NBITS = 21;
  localparam int MBITS = 11;
  localparam int TIMEOUT = 64;
  localparam int LIMIT = 400;
  localparam int AW = 1 + 4 + NBITS;
  localparam int RW = 1 + 4 + MBITS;

  // ---------------- clock / reset / signals ----------------
  logic clk;
  logic reset_n;
  logic frame_flag;
  logic [NREQ-1:0] req;
  logic [NREQ*NBITS-1:0] req_data;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] res_valid;
  logic [MBITS-1:0] res_answer;
  logic res_err;
  logic busy;
  logic sq_start;
  logic [NBITS-1:0] sq_data;
  logic [MBITS-1:0] sq_answer;
  logic sq_done;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_share_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .MBITS(MBITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .frame_flag(frame_flag), .req(req), .req_data(req_data),
    .ack(ack), .res_valid(res_valid), .res_answer(res_answer), .res_err(res_err),
    .busy(busy), .sq_start(sq_start), .sq_data(sq_data), .sq_answer(sq_answer),
    .sq_done(sq_done), .dbg_state(dbg_state)
  );

  // ---------------- behavioural rooter ----------------
  function automatic int isqrt(input int x);
    int r = 0;
    while ((longint'(r) + 1) * (longint'(r) + 1) <= longint'(x)) r++;
    return r;
  endfunction

  logic stuck_en;
  int rcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt <= 0;
      sq_answer <= '0;
    end else if (sq_start) begin
      rcnt <= MBITS + 1;
      sq_answer <= MBITS'(isqrt(int'(sq_data)));
    end else if (rcnt != 0) begin
      rcnt <= rcnt - 1;
    end
  end
  assign sq_done = !stuck_en && !(rcnt >= 1 && rcnt <= MBITS);

  // ---------------- scoreboard state ----------------
  logic [AW-1:0] exp_ack_q[$];
  logic [RW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_ack_cyc = 0;
  int model_ptr = 0;
  int data_arr[NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] enc(input logic [NREQ-1:0] v);
    if ($countones(v) != 1) return 4'hF;
    for (int i = 0; i < NREQ; i++) if (v[i]) return 4'(i);
    return 4'hF;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (ack != '0) begin
          if (exp_ack_q.size() == 0) check("ack_unexpected", 64'(ack), 64'd0);
          else check("ack_grant", 64'({sq_start, enc(ack), sq_data}), 64'(exp_ack_q.pop_front()));
          last_ack_cyc = cyc;
        end
        if (res_valid != '0) begin
          if (exp_q.size() == 0) check("res_unexpected", 64'(res_valid), 64'd0);
          else check("res_result", 64'({res_err, enc(res_valid), res_answer}), 64'(exp_q.pop_front()));
          if (!res_err) check("res_latency", 64'(cyc - last_ack_cyc), 64'(MBITS + 4));
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      int idx = (model_ptr + k) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic push_op(input int g);
    exp_ack_q.push_back({1'b1, 4'(g), NBITS'(data_arr[g])});
    if (stuck_en) exp_q.push_back({1'b1, 4'(g), {MBITS{1'b0}}});
    else exp_q.push_back({1'b0, 4'(g), MBITS'(isqrt(data_arr[g]))});
    model_ptr = (g + 1) % NREQ;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_data(input int i, input int v);
    data_arr[i] = v;
    req_data[i*NBITS +: NBITS] = NBITS'(v);
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] got);
    got = '0;
    for (int t = 0; t < LIMIT; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = ack;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_timeout: no ack within %0d cycles, required one (t=%0t)", LIMIT, $time);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 4 * LIMIT; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_ack_q.size() == 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
  endtask

  task automatic pulse_frame_idle();
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    frame_flag = 1'b1;
    @(negedge clk);
    frame_flag = 1'b0;
    model_ptr = 0;
  endtask

  // hold=1: requesters keep req high for all nops operations; hold=0: each drops on its ack.
  task automatic run_batch(input logic [NREQ-1:0] mask, input int nops, input bit hold);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] got;
    pend = mask;
    for (int k = 0; k < nops; k++) begin
      int g = pick(pend);
      push_op(g);
      if (!hold) pend[g] = 1'b0;
    end
    @(negedge clk);
    req = mask;
    for (int k = 0; k < nops; k++) begin
      wait_ack(got);
      if (!hold) req = req & ~got;
    end
    req = '0;
    wait_drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_answer"}, 64'(res_answer), 64'd0);
    check({tag, "_res_err"}, 64'(res_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sq_start"}, 64'(sq_start), 64'd0);
    check({tag, "_sq_data"}, 64'(sq_data), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NREQ-1:0] got;
    reset_n = 1'b0;
    req = '0;
    req_data = '0;
    frame_flag = 1'b0;
    stuck_en = 1'b0;
    for (int i = 0; i < NREQ; i++) data_arr[i] = 0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    model_ptr = 0;

    // single request
    set_data(0, 441);
    run_batch(3'b001, 1, 1'b0);

    // all three, extreme radicands
    pulse_frame_idle();
    set_data(0, 0);
    set_data(1, 2097151);
    set_data(2, 1000000);
    run_batch(3'b111, 3, 1'b0);

    // fairness between 0 and 2 held continuously
    pulse_frame_idle();
    set_data(0, 144);
    set_data(2, 65535);
    run_batch(3'b101, 6, 1'b1);

    // stuck rooter then a normal op
    stuck_en = 1'b1;
    set_data(1, 12345);
    run_batch(3'b010, 1, 1'b0);
    stuck_en = 1'b0;
    set_data(1, 99);
    run_batch(3'b010, 1, 1'b0);

    // frame pulse during the WAIT of requester 1
    pulse_frame_idle();
    set_data(0, 16);
    set_data(1, 25);
    set_data(2, 36);
    push_op(pick(3'b111));
    push_op(pick(3'b111));
    model_ptr = 0;
    push_op(pick(3'b111));
    @(negedge clk);
    req = 3'b111;
    wait_ack(got);
    wait_ack(got);
    repeat (2) @(negedge clk);
    frame_flag = 1'b1;
    @(negedge clk);
    frame_flag = 1'b0;
    wait_ack(got);
    req = '0;
    wait_drain();

    // reset in the middle of WAIT
    set_data(0, 5000);
    exp_ack_q.push_back({1'b1, 4'd0, NBITS'(5000)});
    @(negedge clk);
    req = 3'b001;
    wait_ack(got);
    req = '0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    model_ptr = 0;
    set_data(2, 1234567);
    req = 3'b100;
    repeat (3) @(negedge clk);
    check("held_reset_res_valid", 64'(res_valid), 64'd0);
    push_op(pick(3'b100));
    reset_n = 1'b1;
    wait_ack(got);
    req = '0;
    wait_drain();

    // randomized batches
    for (int b = 0; b < 10; b++) begin
      logic [NREQ-1:0] mask;
      bit hold;
      int nops;
      if ($urandom_range(0, 2) == 0) pulse_frame_idle();
      for (int i = 0; i < NREQ; i++) set_data(i, int'($urandom_range(0, 2097151)));
      mask = NREQ'($urandom_range(1, 7));
      hold = 1'($urandom_range(0, 1));
      nops = hold ? int'($urandom_range(1, 4)) : $countones(mask);
      run_batch(mask, nops, hold);
    end

    repeat (4) @(negedge clk);
    check("leftover_results", 64'(exp_q.size()), 64'd0);
    check("leftover_acks", 64'(exp_ack_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
